// File: rtl/segway_math_slew.sv
// segway_math_slew: three-stage torque-to-wheel-speed pipeline.
// Stage 1 scales the PID output by the soft-start timer and derives a steering term.
// Stage 2 mixes steering, applies dead-band shaping and saturates.
// Stage 3 slew-limits each wheel command and debounces the overspeed flag.
module segway_math_slew #(
    parameter int              PID_W           = 12,
    parameter int              SPD_W           = 12,
    parameter logic [SPD_W:0]  MIN_DUTY        = 'h3C0,
    parameter logic [SPD_W:0]  LOW_TORQUE_BAND = 'h3C,
    parameter int              GAIN_MULT       = 16,
    parameter logic [SPD_W-1:0] SLEW_STEP      = 'h010,
    parameter int              FAST_THRESH     = 1792,
    parameter int              FAST_CNT        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld,
    input  logic [PID_W-1:0] PID_cntrl,
    input  logic [7:0]       ss_tmr,
    input  logic [11:0]      steer_pot,
    input  logic             en_steer,
    input  logic             pwr_up,
    output logic [SPD_W-1:0] lft_spd,
    output logic [SPD_W-1:0] rght_spd,
    output logic             spd_vld,
    output logic             too_fast
);

    localparam logic signed [SPD_W:0]   SAT_MAX   = (SPD_W+1)'((2 ** (SPD_W - 1)) - 1);
    localparam logic signed [SPD_W:0]   SAT_MIN   = (SPD_W+1)'(-(2 ** (SPD_W - 1)));
    localparam logic signed [SPD_W-1:0] THRESH    = (SPD_W)'(FAST_THRESH);
    localparam logic [3:0]              CNT_MAX   = 4'(FAST_CNT);

    // Dead-band shaping followed by signed saturation to the speed width.
    function automatic logic signed [SPD_W-1:0] shape_sat(input logic signed [SPD_W:0] t);
        logic signed [SPD_W:0] mag;
        logic signed [SPD_W:0] shp;
        mag = (t < 0) ? -t : t;
        if (mag > $signed(LOW_TORQUE_BAND))
            shp = (t < 0) ? t - $signed(MIN_DUTY) : t + $signed(MIN_DUTY);
        else
            shp = (SPD_W+1)'(t * GAIN_MULT);
        if (shp > SAT_MAX)
            shp = SAT_MAX;
        else if (shp < SAT_MIN)
            shp = SAT_MIN;
        return shp[SPD_W-1:0];
    endfunction

    // Move cur toward tgt by at most SLEW_STEP; land exactly on tgt when close enough.
    function automatic logic signed [SPD_W-1:0] slew(input logic signed [SPD_W-1:0] tgt,
                                                     input logic signed [SPD_W-1:0] cur);
        logic signed [SPD_W:0] delta;
        logic signed [SPD_W:0] step;
        delta = (SPD_W+1)'(tgt) - (SPD_W+1)'(cur);
        step  = $signed({1'b0, SLEW_STEP});
        if (delta > step)
            return cur + $signed(SLEW_STEP);
        else if (delta < -step)
            return cur - $signed(SLEW_STEP);
        else
            return tgt;
    endfunction

    // ---------------- stage 1 combinational ----------------
    logic signed [PID_W+8:0] w_prod;
    logic signed [SPD_W:0]   w_pid_ss;
    logic [11:0]             w_pot_clip;
    logic signed [12:0]      w_pot_off;
    logic signed [12:0]      w_pot_sh;
    logic signed [SPD_W:0]   w_steer;

    assign w_prod    = $signed(PID_cntrl) * $signed({1'b0, ss_tmr});
    assign w_pid_ss  = (SPD_W+1)'(w_prod >>> 8);
    assign w_pot_off = $signed({1'b0, w_pot_clip}) - 13'sd2047;
    assign w_pot_sh  = w_pot_off >>> 4;
    assign w_steer   = (SPD_W+1)'(w_pot_sh * 13'sd3);

    // Clip the steering pot to its usable mechanical range.
    always_comb begin
        w_pot_clip = steer_pot;
        if (steer_pot < 12'h200)
            w_pot_clip = 12'h200;
        else if (steer_pot > 12'hE00)
            w_pot_clip = 12'hE00;
    end

    logic                  r_s1_vld;
    logic signed [SPD_W:0] r_s1_pid;
    logic signed [SPD_W:0] r_s1_steer;
    logic                  r_s1_en;
    logic                  r_s1_pwr;

    // Stage 1 register: capture scaled torque and steering term on each sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_pid   <= '0;
            r_s1_steer <= '0;
            r_s1_en    <= 1'b0;
            r_s1_pwr   <= 1'b0;
        end else begin
            r_s1_vld <= vld;
            if (vld) begin
                r_s1_pid   <= w_pid_ss;
                r_s1_steer <= w_steer;
                r_s1_en    <= en_steer;
                r_s1_pwr   <= pwr_up;
            end
        end
    end

    // ---------------- stage 2 combinational ----------------
    logic signed [SPD_W:0] w_mix_l;
    logic signed [SPD_W:0] w_mix_r;

    assign w_mix_l = r_s1_en ? r_s1_pid + r_s1_steer : r_s1_pid;
    assign w_mix_r = r_s1_en ? r_s1_pid - r_s1_steer : r_s1_pid;

    logic                    r_s2_vld;
    logic signed [SPD_W-1:0] r_s2_lft;
    logic signed [SPD_W-1:0] r_s2_rght;
    logic                    r_s2_byp;

    // Stage 2 register: shaped, saturated targets; power-down zeroes them and flags bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_lft  <= '0;
            r_s2_rght <= '0;
            r_s2_byp  <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_lft  <= r_s1_pwr ? shape_sat(w_mix_l) : '0;
                r_s2_rght <= r_s1_pwr ? shape_sat(w_mix_r) : '0;
                r_s2_byp  <= ~r_s1_pwr;
            end
        end
    end

    // ---------------- stage 3 ----------------
    logic signed [SPD_W-1:0] r_lft;
    logic signed [SPD_W-1:0] r_rght;
    logic                    r_spd_vld;
    logic                    r_too_fast;
    logic [3:0]              r_fast_cnt;

    logic signed [SPD_W-1:0] w_nxt_lft;
    logic signed [SPD_W-1:0] w_nxt_rght;
    logic [3:0]              w_nxt_cnt;

    // Next outputs and overspeed count; bypass drops straight to zero.
    always_comb begin
        w_nxt_lft  = '0;
        w_nxt_rght = '0;
        w_nxt_cnt  = '0;
        if (!r_s2_byp) begin
            w_nxt_lft  = slew(r_s2_lft, r_lft);
            w_nxt_rght = slew(r_s2_rght, r_rght);
            if ((w_nxt_lft > THRESH) || (w_nxt_rght > THRESH))
                w_nxt_cnt = (r_fast_cnt == CNT_MAX) ? r_fast_cnt : r_fast_cnt + 4'd1;
        end
    end

    // Stage 3 register: wheel commands, update strobe and debounced overspeed flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft      <= '0;
            r_rght     <= '0;
            r_spd_vld  <= 1'b0;
            r_too_fast <= 1'b0;
            r_fast_cnt <= '0;
        end else begin
            r_spd_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_lft      <= w_nxt_lft;
                r_rght     <= w_nxt_rght;
                r_fast_cnt <= w_nxt_cnt;
                r_too_fast <= (w_nxt_cnt == CNT_MAX);
            end
        end
    end

    assign lft_spd  = r_lft;
    assign rght_spd = r_rght;
    assign spd_vld  = r_spd_vld;
    assign too_fast = r_too_fast;

endmodule

// File: doc/segway_math_slew.md
Name: segway_math_slew

Overview:
Parameterised, pipelined successor to the Segway torque-math block. It turns PID output, soft-start timer and steering pot into left/right wheel speed commands. Samples arrive under a valid strobe and pass through a 3-stage pipeline: scale/steer, shape/saturate, slew-limit. Downstream output slew limiting and a debounced too_fast flag are added. It sits between the PID block and the motor-drive PWM block.

Parameters:
PID_W, 12, signed width of PID_cntrl
SPD_W, 12, signed width of lft_spd/rght_spd; torque path is SPD_W+1 bits
MIN_DUTY, 'h3C0, dead-band offset added to |torque| outside the low band (SPD_W+1 bits)
LOW_TORQUE_BAND, 'h3C, |torque| at or below this uses gain instead of offset
GAIN_MULT, 16, low-band torque multiplier
SLEW_STEP, 'h010, max |change| of each speed output per valid sample (SPD_W bits, unsigned, >0)
FAST_THRESH, 1792, signed speed above which a sample counts as too fast
FAST_CNT, 4, consecutive too-fast samples needed to assert too_fast (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vld  in  1  new sample strobe; inputs are sampled on any cycle with vld=1
PID_cntrl  in  PID_W  signed PID output
ss_tmr  in  8  unsigned soft-start scale
steer_pot  in  12  unsigned steering pot reading
en_steer  in  1  steering enable
pwr_up  in  1  drive enable
lft_spd  out  SPD_W  signed left speed command
rght_spd  out  SPD_W  signed right speed command
spd_vld  out  1  one-cycle pulse when lft_spd/rght_spd update
too_fast  out  1  debounced overspeed flag

Behaviour:
- Reset (async): all pipeline registers, lft_spd, rght_spd, spd_vld, too_fast and the fast counter go to 0. Reset mid-pipeline discards in-flight samples; no spd_vld follows.
- Pipeline accepts one sample per cycle with no back-pressure. A valid bit travels with each stage. spd_vld is asserted exactly 3 cycles after vld, and consecutive vld cycles give consecutive spd_vld pulses.
- Stage 1, registered on vld:
  - PID_ss = (PID_cntrl * {0,ss_tmr}) >>> 8, arithmetic shift, sign-extended to SPD_W+1.
  - steer: clip steer_pot to ['h200,'hE00], subtract 'h7FF, >>> 4 arithmetic, then *3 (signed).
  - en_steer and pwr_up are registered alongside the sample.
- Stage 2:
  - lft = PID_ss + steer, rght = PID_ss - steer when en_steer=1; both = PID_ss otherwise.
  - Shaping per side: if |t| > LOW_TORQUE_BAND, t +/- MIN_DUTY (sign of t); else t*GAIN_MULT. All math in SPD_W+1 bits.
  - Saturate signed to SPD_W: max 2^(SPD_W-1)-1, min -2^(SPD_W-1).
  - pwr_up=0 forces both targets to 0 and sets a bypass flag.
- Stage 3, on stage-2 valid, per side:
  - delta = target - current output, computed in SPD_W+1 bits.
  - delta > SLEW_STEP: out += SLEW_STEP; delta < -SLEW_STEP: out -= SLEW_STEP; otherwise out = target.
  - Bypass flag set: out = 0 immediately, with no slew.
- Outputs hold their value between spd_vld pulses.
- too_fast counter updates with stage 3:
  - If the new lft_spd or rght_spd > FAST_THRESH (signed compare), counter increments, saturating at FAST_CNT; otherwise counter clears to 0.
  - too_fast = (counter == FAST_CNT), registered, and updates in the same cycle as spd_vld.
  - Bypass clears the counter.
- Inputs are ignored when vld=0.

Test Plan:
- SLEW_STEP='h7FF; PID_cntrl='h100, ss_tmr='hFF, en_steer=0, pwr_up=1, single vld -> 3 cycles later spd_vld pulse, lft_spd=rght_spd='h4BF (255+960).
- SLEW_STEP='h7FF; PID_cntrl='h020, ss_tmr='hFF -> 'h1F0 (31*16, low band). PID_cntrl='hF00 (-256) -> 'hB41 (-1215).
- SLEW_STEP='h7FF; PID_cntrl='h100, ss_tmr='hFF, en_steer=1, steer_pot='hFFF (clips to 'hE00, steer=288) -> lft_spd=1503 ('h5DF), rght_spd=-528 ('hDF0).
- Default SLEW_STEP='h010; from reset, repeated vld with target 'h4BF -> outputs 16, 32, 48, ..., 1200, then 1215 on the 76th sample. Drop pwr_up -> next spd_vld gives 0 on both sides at once.
- SLEW_STEP='h7FF; PID_cntrl='h7FF, ss_tmr='hFF -> outputs saturate to 'h7FF. too_fast rises on the 4th consecutive spd_vld; one sample with PID_cntrl=0 clears it on that spd_vld.
- vld on 5 back-to-back cycles, then rst_n low for 1 cycle mid-stream -> outputs, spd_vld and too_fast are 0 immediately. No spd_vld for discarded samples; the next vld after reset gives spd_vld 3 cycles later.
